// File: rtl/crm_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crm_loader: CRAM write-side loader. Collects four 21-bit pieces into an   |
// | 84-bit microword and commits it to cram_mem port A, auto-incrementing.    |
// | Option macro: CRM_LOADER_PARITY_EN (cramDin[0] becomes odd parity).       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module crm_loader #(
  parameter int ADDR_W  = 12,
  parameter int PIECE_W = 21
) (
  input  logic                   eboxClk,
  input  logic                   eboxReset,
  input  logic                   loadValid,
  output logic                   loadReady,
  input  logic [2:0]             loadFunc,
  input  logic [PIECE_W-1:0]     loadData,
  output logic                   cramWea,
  output logic [ADDR_W-1:0]      cramAddr,
  output logic [0:4*PIECE_W-1]   cramDin,
  output logic                   loadDone,
  output logic                   loadErr,
  output logic [ADDR_W-1:0]      curAdr
);

  localparam int c_WORD_W = 4 * PIECE_W;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;

  localparam logic [2:0] c_F_SETADR = 3'd0;
  localparam logic [2:0] c_F_PIECE0 = 3'd1;
  localparam logic [2:0] c_F_PIECE1 = 3'd2;
  localparam logic [2:0] c_F_PIECE2 = 3'd3;
  localparam logic [2:0] c_F_PIECE3 = 3'd4;
  localparam logic [2:0] c_F_COMMIT = 3'd5;
  localparam logic [2:0] c_F_CLRERR = 3'd6;

  localparam logic [ADDR_W-1:0] c_ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [PIECE_W-1:0]    r_buf0, r_buf1, r_buf2, r_buf3;
  logic [3:0]            r_mask;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_adr;
  logic [ADDR_W-1:0]     r_cram_addr;
  logic [0:c_WORD_W-1]   r_cram_din;
  logic [0:c_WORD_W-1]   w_word;
  logic [0:c_WORD_W-1]   w_din;
  logic                  w_accept;

  // Word bit 0 (MSB) comes from piece 0, matching the 0:83 numbering crm reads.
  assign w_word = {r_buf0, r_buf1, r_buf2, r_buf3};

`ifdef CRM_LOADER_PARITY_EN
  assign w_din = {~^w_word[1:c_WORD_W-1], w_word[1:c_WORD_W-1]};
`else
  assign w_din = w_word;
`endif

  assign loadReady = (r_state == c_IDLE);
  assign w_accept  = loadValid && loadReady;
  assign cramWea   = (r_state == c_WRITE);
  assign loadDone  = (r_state == c_HOLD);
  assign cramAddr  = r_cram_addr;
  assign cramDin   = r_cram_din;
  assign loadErr   = r_err;
  assign curAdr    = r_adr;

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      r_state     <= c_IDLE;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_buf2      <= '0;
      r_buf3      <= '0;
      r_mask      <= 4'b0000;
      r_err       <= 1'b0;
      r_adr       <= '0;
      r_cram_addr <= '0;
      r_cram_din  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            case (loadFunc)
              c_F_SETADR: begin
                r_adr  <= loadData[ADDR_W-1:0];
                r_mask <= 4'b0000;
              end
              c_F_PIECE0: begin r_buf0 <= loadData; r_mask[0] <= 1'b1; end
              c_F_PIECE1: begin r_buf1 <= loadData; r_mask[1] <= 1'b1; end
              c_F_PIECE2: begin r_buf2 <= loadData; r_mask[2] <= 1'b1; end
              c_F_PIECE3: begin r_buf3 <= loadData; r_mask[3] <= 1'b1; end
              c_F_COMMIT: begin
                // Address and data are captured here so they stay frozen through WRITE and HOLD.
                if (&r_mask) begin
                  r_state     <= c_WRITE;
                  r_cram_addr <= r_adr;
                  r_cram_din  <= w_din;
                end else begin
                  r_err <= 1'b1;
                end
              end
              c_F_CLRERR: r_err <= 1'b0;
              default:    r_err <= 1'b1;
            endcase
          end
        end
        c_WRITE: r_state <= c_HOLD;
        c_HOLD: begin
          r_state <= c_IDLE;
          r_adr   <= r_adr + c_ADR_ONE;
          r_mask  <= 4'b0000;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crm_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crm_loader: table-driven self-checking bench for crm_loader.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_crm_loader;

  localparam logic [2:0] F_SETADR = 3'd0;
  localparam logic [2:0] F_P0     = 3'd1;
  localparam logic [2:0] F_P1     = 3'd2;
  localparam logic [2:0] F_P2     = 3'd3;
  localparam logic [2:0] F_P3     = 3'd4;
  localparam logic [2:0] F_COMMIT = 3'd5;
  localparam logic [2:0] F_CLRERR = 3'd6;
  localparam logic [2:0] F_RSVD   = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadValid;
  logic        loadReady;
  logic [2:0]  loadFunc;
  logic [20:0] loadData;
  logic        cramWea;
  logic [11:0] cramAddr;
  logic [0:83] cramDin;
  logic        loadDone;
  logic        loadErr;
  logic [11:0] curAdr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  func;
    logic [20:0] data;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [83:0] exp_din;
    logic        exp_err;
    logic [11:0] exp_cur;
  } vec_t;

  vec_t vt[$];

  crm_loader dut (
    .eboxClk   (clk),
    .eboxReset (rst),
    .loadValid (loadValid),
    .loadReady (loadReady),
    .loadFunc  (loadFunc),
    .loadData  (loadData),
    .cramWea   (cramWea),
    .cramAddr  (cramAddr),
    .cramDin   (cramDin),
    .loadDone  (loadDone),
    .loadErr   (loadErr),
    .curAdr    (curAdr)
  );

  always #5 clk = ~clk;

  function automatic logic [83:0] mkword(input logic [20:0] a, input logic [20:0] b,
                                         input logic [20:0] c, input logic [20:0] d);
    logic [83:0] w;
    w = {a, b, c, d};
`ifdef CRM_LOADER_PARITY_EN
    w[83] = ~^w[82:0];
`endif
    return w;
  endfunction

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] f, input logic [20:0] d, input logic wr,
                     input logic [11:0] a, input logic [83:0] din,
                     input logic err, input logic [11:0] cur);
    vec_t v;
    v.func = f; v.data = d; v.exp_wr = wr; v.exp_addr = a;
    v.exp_din = din; v.exp_err = err; v.exp_cur = cur;
    vt.push_back(v);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [2:0] f, input logic [20:0] d);
    int n = 0;
    while (loadReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: loadReady stuck at %b, required 1", loadReady);
    end
    loadValid = 1'b1; loadFunc = f; loadData = d;
    @(posedge clk);
    @(negedge clk);
    loadValid = 1'b0;
  endtask

  task automatic add_word(input logic [20:0] p0, input logic [20:0] p1, input logic [20:0] p2,
                          input logic [20:0] p3, input logic [11:0] a, input logic err);
    add(F_P0, p0, 1'b0, 12'h0, 84'h0, err, a);
    add(F_P1, p1, 1'b0, 12'h0, 84'h0, err, a);
    add(F_P2, p2, 1'b0, 12'h0, 84'h0, err, a);
    add(F_P3, p3, 1'b0, 12'h0, 84'h0, err, a);
    add(F_COMMIT, 21'h0, 1'b1, a, mkword(p0, p1, p2, p3), err, a + 12'd1);
  endtask

  initial begin
    int dones;
    rst = 1'b1; loadValid = 1'b0; loadFunc = 3'd0; loadData = 21'h0;

    // Test 1: basic word at 0100 octal
    add(F_SETADR, 21'o0100, 1'b0, 12'h0, 84'h0, 1'b0, 12'o0100);
    add_word(21'h1ABCDE, 21'h012345, 21'h0FFFFF, 21'h000001, 12'o0100, 1'b0);
    // Test 2: streaming across the 4095 -> 0 wrap
    add(F_SETADR, 21'o7776, 1'b0, 12'h0, 84'h0, 1'b0, 12'o7776);
    add_word(21'h000001, 21'h000002, 21'h000003, 21'h000004, 12'o7776, 1'b0);
    add_word(21'h1FFFFF, 21'h000000, 21'h1FFFFF, 21'h000000, 12'o7777, 1'b0);
    add_word(21'h155555, 21'h0AAAAA, 21'h123456, 21'h054321, 12'o0000, 1'b0);
    // Test 3: incomplete commit raises the sticky error, buffers survive
    add(F_SETADR, 21'd5, 1'b0, 12'h0, 84'h0, 1'b0, 12'd5);
    add(F_P0, 21'h000011, 1'b0, 12'h0, 84'h0, 1'b0, 12'd5);
    add(F_P1, 21'h000022, 1'b0, 12'h0, 84'h0, 1'b0, 12'd5);
    add(F_P2, 21'h000033, 1'b0, 12'h0, 84'h0, 1'b0, 12'd5);
    add(F_COMMIT, 21'h0, 1'b0, 12'h0, 84'h0, 1'b1, 12'd5);
    add(F_P3, 21'h000044, 1'b0, 12'h0, 84'h0, 1'b1, 12'd5);
    add(F_COMMIT, 21'h0, 1'b1, 12'd5, mkword(21'h000011, 21'h000022, 21'h000033, 21'h000044),
        1'b1, 12'd6);
    add(F_CLRERR, 21'h0, 1'b0, 12'h0, 84'h0, 1'b0, 12'd6);
    // Test 4: rewritten piece, last write wins
    add(F_SETADR, 21'h200, 1'b0, 12'h0, 84'h0, 1'b0, 12'h200);
    add(F_P1, 21'h000AAA, 1'b0, 12'h0, 84'h0, 1'b0, 12'h200);
    add_word(21'h0F0F0F, 21'h000555, 21'h1C3C3C, 21'h0ABCDE, 12'h200, 1'b0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", loadReady, 1'b1);
    chk("rst_wea", cramWea, 1'b0);
    chk("rst_addr", cramAddr, 12'h0);
    chk("rst_din", cramDin, 84'h0);
    chk("rst_done", loadDone, 1'b0);
    chk("rst_err", loadErr, 1'b0);
    chk("rst_cur", curAdr, 12'h0);

    foreach (vt[i]) begin
      issue(vt[i].func, vt[i].data);
      if (vt[i].exp_wr) begin
        chk("wr_wea", cramWea, 1'b1);
        chk("wr_addr", cramAddr, vt[i].exp_addr);
        chk("wr_din", cramDin, vt[i].exp_din);
        chk("wr_ready", loadReady, 1'b0);
        chk("wr_done", loadDone, 1'b0);
        @(negedge clk);
        chk("hold_wea", cramWea, 1'b0);
        chk("hold_done", loadDone, 1'b1);
        chk("hold_addr", cramAddr, vt[i].exp_addr);
        chk("hold_din", cramDin, vt[i].exp_din);
        chk("hold_ready", loadReady, 1'b0);
        @(negedge clk);
        chk("post_ready", loadReady, 1'b1);
        chk("post_done", loadDone, 1'b0);
        chk("post_wea", cramWea, 1'b0);
      end else begin
        chk("no_wea", cramWea, 1'b0);
      end
      chk("err", loadErr, vt[i].exp_err);
      chk("cur", curAdr, vt[i].exp_cur);
    end

    // Test 4 explicit field check: word bits 21..41 carry the rewritten piece
    begin
      logic [83:0] w;
      w = cramDin;
      chk("piece1_field", w[62:42], 21'h000555);
    end

    // Test 5: reset while cramWea is high
    issue(F_RSVD, 21'h0);
    issue(F_SETADR, 21'h321);
    issue(F_P0, 21'h1); issue(F_P1, 21'h2); issue(F_P2, 21'h3); issue(F_P3, 21'h4);
    issue(F_COMMIT, 21'h0);
    chk("r5_wea_before", cramWea, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("r5_wea", cramWea, 1'b0);
    chk("r5_cur", curAdr, 12'h0);
    chk("r5_err", loadErr, 1'b0);
    chk("r5_addr", cramAddr, 12'h0);
    chk("r5_din", cramDin, 84'h0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (loadDone) dones++;
      @(negedge clk);
    end
    chk("r5_no_done", dones, 0);
    issue(F_COMMIT, 21'h0);
    chk("r5_mask_wea", cramWea, 1'b0);
    chk("r5_mask_err", loadErr, 1'b1);
    issue(F_CLRERR, 21'h0);

    // Test 6: command held while busy is consumed only once back in IDLE
    issue(F_SETADR, 21'h123);
    issue(F_P0, 21'h000101); issue(F_P1, 21'h000202);
    issue(F_P2, 21'h000303); issue(F_P3, 21'h000404);
    loadValid = 1'b1; loadFunc = F_COMMIT; loadData = 21'h0;
    @(posedge clk);
    @(negedge clk);
    loadFunc = F_P0; loadData = 21'h0AAAAA;
    chk("h6_wea", cramWea, 1'b1);
    chk("h6_ready_w", loadReady, 1'b0);
    chk("h6_din_w", cramDin, mkword(21'h000101, 21'h000202, 21'h000303, 21'h000404));
    @(posedge clk);
    @(negedge clk);
    chk("h6_done", loadDone, 1'b1);
    chk("h6_ready_h", loadReady, 1'b0);
    chk("h6_din_h", cramDin, mkword(21'h000101, 21'h000202, 21'h000303, 21'h000404));
    @(posedge clk);
    @(negedge clk);
    chk("h6_ready_i", loadReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    loadValid = 1'b0;
    chk("h6_cur", curAdr, 12'h124);
    issue(F_P1, 21'h000202); issue(F_P2, 21'h000303); issue(F_P3, 21'h000404);
    issue(F_COMMIT, 21'h0);
    chk("h6_wea2", cramWea, 1'b1);
    chk("h6_addr2", cramAddr, 12'h124);
    chk("h6_din2", cramDin, mkword(21'h0AAAAA, 21'h000202, 21'h000303, 21'h000404));
    chk("h6_err2", loadErr, 1'b0);
    issue(F_RSVD, 21'h0);
    chk("f7_err", loadErr, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
